// File: rtl/linterp_pkg.sv
// Shared types and width helpers for the linear-interpolator inverse.
package linterp_pkg;

   // Controller states: accept, normalize/classify, divide, present result.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SETUP = 2'd1,
      DIV   = 2'd2,
      DONE  = 2'd3
   } state_t;

   // Default geometry, matching the signal path's interpolator.
   localparam int DEF_WIDTH     = 8;
   localparam int DEF_PRECISION = 16;

   // Endpoint difference needs one extra bit to hold high - low.
   function automatic int den_width(input int width);
      return width + 1;
   endfunction

   // Numerator and remainder: target minus shifted low, then a possible
   // negation, so two guard bits above the target format.
   function automatic int num_width(input int width, input int precision);
      return width + precision + 2;
   endfunction

   // Bit counter / shift index width for walking the quotient bits.
   function automatic int cnt_width(input int precision);
      return (precision > 1) ? $clog2(precision) : 1;
   endfunction

endpackage

// File: rtl/frac_div_step.sv
// One restoring-division step: trial-subtract den << shift from the remainder.
module frac_div_step #(
   parameter int NW = 26,
   parameter int DW = 9,
   parameter int SW = 4
) (
   input  logic [NW-1:0] rem,
   input  logic [DW-1:0] den,
   input  logic [SW-1:0] shift,
   output logic [NW-1:0] rem_next,
   output logic          q_bit
);

   logic [NW-1:0] den_shift;
   logic          fits;

   // Both operands are non-negative here, so an unsigned compare is exact.
   always_comb begin
      den_shift = {{(NW-DW){1'b0}}, den} << shift;
      fits      = (rem >= den_shift);
      rem_next  = fits ? (rem - den_shift) : rem;
      q_bit     = fits;
   end

endmodule

// File: rtl/linterp_frac.sv
// Finds the fraction c such that low*2^P + (high-low)*c brackets the target.
module linterp_frac
   import linterp_pkg::*;
#(
   parameter int WIDTH     = DEF_WIDTH,
   parameter int PRECISION = DEF_PRECISION
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        i_valid,
   output logic                        o_ready,
   input  logic signed [WIDTH-1:0]     i_high_signed,
   input  logic signed [WIDTH-1:0]     i_low_signed,
   input  logic signed [WIDTH+PRECISION-1:0] i_target,
   output logic                        o_valid,
   input  logic                        i_ready,
   output logic [PRECISION-1:0]        o_ctrl,
   output logic                        o_clamp_low,
   output logic                        o_clamp_high,
   output logic                        o_degenerate
);

   localparam int DW = den_width(WIDTH);
   localparam int NW = num_width(WIDTH, PRECISION);
   localparam int CW = cnt_width(PRECISION);
   localparam int TW = WIDTH + PRECISION;

   state_t state_reg, state_next;

   // Captured request; held for the whole operation.
   logic signed [WIDTH-1:0] high_reg, low_reg;
   logic signed [TW-1:0]    target_reg;

   // Divider working state.
   logic [DW-1:0]        den_reg;
   logic [NW-1:0]        rem_reg;
   logic [PRECISION-1:0] q_reg;
   logic [CW-1:0]        cnt_reg;

   // SETUP-stage combinational values.
   logic signed [DW-1:0] den_raw, den_abs;
   logic signed [NW-1:0] num_raw, num_n, den_lim;
   logic                 is_degen, is_low, is_high, is_special;

   // DIV-stage combinational values.
   logic [CW-1:0]        idx;
   logic [NW-1:0]        step_rem;
   logic                 step_q;
   logic [PRECISION-1:0] q_next;
   logic                 last_bit;

   // Handshake outputs come straight from the state register.
   assign o_ready = (state_reg == IDLE);
   assign o_valid = (state_reg == DONE);

   // Sign-normalize the operands and classify the special cases.
   always_comb begin
      den_raw  = {high_reg[WIDTH-1], high_reg} - {low_reg[WIDTH-1], low_reg};
      num_raw  = {{2{target_reg[TW-1]}}, target_reg}
               - {{2{low_reg[WIDTH-1]}}, low_reg, {PRECISION{1'b0}}};
      den_abs  = den_raw[DW-1] ? -den_raw : den_raw;
      num_n    = den_raw[DW-1] ? -num_raw : num_raw;
      den_lim  = {{(NW-DW){1'b0}}, den_abs} << PRECISION;
      is_degen = (den_abs == '0);
      is_low   = num_n[NW-1];
      is_high  = !is_low && (num_n >= den_lim);
      is_special = is_degen || is_low || is_high;
   end

   // Quotient bits are produced MSB first: bit index = PRECISION-1-count.
   always_comb begin
      idx      = CW'(PRECISION - 1) - cnt_reg;
      last_bit = (cnt_reg == CW'(PRECISION - 1));
      q_next   = q_reg | (PRECISION'(step_q) << idx);
   end

   frac_div_step #(
      .NW (NW),
      .DW (DW),
      .SW (CW)
   ) u_step (
      .rem      (rem_reg),
      .den      (den_reg),
      .shift    (idx),
      .rem_next (step_rem),
      .q_bit    (step_q)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state decode.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (i_valid) state_next = SETUP;
         SETUP:   state_next = is_special ? DONE : DIV;
         DIV:     if (last_bit) state_next = DONE;
         DONE:    if (i_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Datapath: capture, setup, iterate, and load results on entry to DONE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         high_reg     <= '0;
         low_reg      <= '0;
         target_reg   <= '0;
         den_reg      <= '0;
         rem_reg      <= '0;
         q_reg        <= '0;
         cnt_reg      <= '0;
         o_ctrl       <= '0;
         o_clamp_low  <= 1'b0;
         o_clamp_high <= 1'b0;
         o_degenerate <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (i_valid) begin
                  high_reg   <= i_high_signed;
                  low_reg    <= i_low_signed;
                  target_reg <= i_target;
               end
            end
            SETUP: begin
               den_reg <= den_abs;
               rem_reg <= num_n;
               q_reg   <= '0;
               cnt_reg <= '0;
               if (is_degen) begin
                  o_ctrl       <= '0;
                  o_degenerate <= 1'b1;
                  o_clamp_low  <= 1'b0;
                  o_clamp_high <= 1'b0;
               end else if (is_low) begin
                  o_ctrl       <= '0;
                  o_degenerate <= 1'b0;
                  o_clamp_low  <= 1'b1;
                  o_clamp_high <= 1'b0;
               end else if (is_high) begin
                  o_ctrl       <= '1;
                  o_degenerate <= 1'b0;
                  o_clamp_low  <= 1'b0;
                  o_clamp_high <= 1'b1;
               end
            end
            DIV: begin
               rem_reg <= step_rem;
               q_reg   <= q_next;
               cnt_reg <= cnt_reg + CW'(1);
               if (last_bit) begin
                  o_ctrl       <= q_next;
                  o_degenerate <= 1'b0;
                  o_clamp_low  <= 1'b0;
                  o_clamp_high <= 1'b0;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule
